// File: rtl/fetch_pkg.sv
// Shared types and sizing for the Fetch0 control slice.
// Pure declarations: no logic, no latency.
// Counter widths here bound the credit/outstanding checks in fetch_ctrl.
package fetch_pkg;
  localparam int IQ_DEPTH  = 8;   // instQueue entries, i.e. credit pool size
  localparam int MAX_OUTST = 4;   // Icache requests allowed in flight
  localparam int DEQ_W     = 2;   // max instQueue pops per cycle
  localparam int EPOCH_W   = 2;   // fetch epoch tag width

  localparam int DEQ_CW  = $clog2(DEQ_W + 1);
  localparam int USED_W  = $clog2(IQ_DEPTH + 1);
  localparam int OUTST_W = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_DEC  = 2'd2,
    SRC_BP   = 2'd3
  } redir_src_e;
endpackage

// File: rtl/fetch_redir_arb.sv
// Fixed-priority redirect select (wb > dec > bp) with decode epoch filtering.
// Latency: purely combinational, result is registered by the caller.
// Backpressure: none; losing requests are dropped, never held.
module fetch_redir_arb
  import fetch_pkg::*;
(
  input  logic               wb_redir_i,
  input  logic [63:0]        wb_redir_pc_i,
  input  logic               dec_redir_i,
  input  logic [63:0]        dec_redir_pc_i,
  input  logic [EPOCH_W-1:0] dec_epoch_i,
  input  logic [EPOCH_W-1:0] cur_epoch_i,
  input  logic               bp_redir_i,
  input  logic [63:0]        bp_redir_pc_i,
  output redir_src_e         win_src_o,
  output logic [63:0]        win_pc_o
);

  // Pick the highest-priority live source; decode from an older epoch is stale
  always_comb begin
    win_src_o = SRC_NONE;
    win_pc_o  = '0;
    if (wb_redir_i) begin
      win_src_o = SRC_WB;
      win_pc_o  = wb_redir_pc_i;
    end else if (dec_redir_i && (dec_epoch_i == cur_epoch_i)) begin
      win_src_o = SRC_DEC;
      win_pc_o  = dec_redir_pc_i;
    end else if (bp_redir_i) begin
      win_src_o = SRC_BP;
      win_pc_o  = bp_redir_pc_i;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch0 sequencer: redirect arbitration, fetch epoch, IQ-credit / in-flight accounting.
// Latency: redirect winner at cycle N shows on redir_o/redir_pc_o/flush_o/epoch_o at N+1.
// Backpressure: stall_f0_o from registered credits/in-flight/state plus live ic_ready_i.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ic_init_done_i,
  input  logic               wb_redir_i,
  input  logic [63:0]        wb_redir_pc_i,
  input  logic               dec_redir_i,
  input  logic [63:0]        dec_redir_pc_i,
  input  logic [EPOCH_W-1:0] dec_epoch_i,
  input  logic               bp_redir_i,
  input  logic [63:0]        bp_redir_pc_i,
  input  logic               f0_valid_i,
  input  logic               ic_ready_i,
  input  logic               ic_resp_i,
  input  logic [EPOCH_W-1:0] ic_resp_epoch_i,
  input  logic [DEQ_CW-1:0]  iq_deq_cnt_i,
  output logic               redir_o,
  output logic [63:0]        redir_pc_o,
  output logic               stall_f0_o,
  output logic               flush_o,
  output logic [EPOCH_W-1:0] epoch_o
);

  fetch_state_e       state_q;
  logic               redir_q;
  logic [63:0]        redir_pc_q;
  logic               flush_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic               pend_q;
  logic [63:0]        pend_pc_q;
  logic [USED_W-1:0]  used_q, used_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  redir_src_e         win_src;
  logic [63:0]        win_pc;
  logic               fire;
  logic               stale_resp;

  fetch_redir_arb u_arb (
    .wb_redir_i     (wb_redir_i),
    .wb_redir_pc_i  (wb_redir_pc_i),
    .dec_redir_i    (dec_redir_i),
    .dec_redir_pc_i (dec_redir_pc_i),
    .dec_epoch_i    (dec_epoch_i),
    .cur_epoch_i    (epoch_q),
    .bp_redir_i     (bp_redir_i),
    .bp_redir_pc_i  (bp_redir_pc_i),
    .win_src_o      (win_src),
    .win_pc_o       (win_pc)
  );

  // A full pool only frees on the cycle after a pop, since used_q is registered
  assign stall_f0_o = (state_q != RUN) | (used_q == USED_W'(IQ_DEPTH)) |
                      (outst_q == OUTST_W'(MAX_OUTST)) | !ic_ready_i;
  assign fire       = f0_valid_i & ic_ready_i & !stall_f0_o;
  assign stale_resp = ic_resp_i & (ic_resp_epoch_i != epoch_q);

  // Next credit state; a flush drops queue content but keeps in-flight slots reserved
  always_comb begin
    outst_d = outst_q + OUTST_W'(fire) - OUTST_W'(ic_resp_i);
    if (flush_q) begin
      used_d = USED_W'(outst_d);
    end else begin
      used_d = used_q + USED_W'(fire) - USED_W'(iq_deq_cnt_i) - USED_W'(stale_resp);
    end
  end

  // Credit and in-flight counters
  always_ff @(posedge clk) begin
    if (rst) begin
      used_q  <= '0;
      outst_q <= '0;
    end else begin
      used_q  <= used_d;
      outst_q <= outst_d;
    end
  end

  // Control FSM with registered redirect, flush and epoch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      flush_q    <= 1'b0;
      epoch_q    <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      redir_q <= 1'b0;
      flush_q <= 1'b0;
      unique case (state_q)
        INIT: begin
          // Only a writeback target survives init; it is replayed on the first RUN cycle
          if (wb_redir_i) begin
            pend_q    <= 1'b1;
            pend_pc_q <= wb_redir_pc_i;
          end
          if (ic_init_done_i) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            if (wb_redir_i || pend_q) begin
              redir_q    <= 1'b1;
              redir_pc_q <= wb_redir_i ? wb_redir_pc_i : pend_pc_q;
            end
          end
        end
        RUN, REDIR: begin
          if (win_src != SRC_NONE) begin
            state_q    <= REDIR;
            redir_q    <= 1'b1;
            redir_pc_q <= win_pc;
            flush_q    <= (win_src == SRC_WB);
            if (win_src != SRC_BP) begin
              epoch_q <= epoch_q + EPOCH_W'(1);
            end
          end else begin
            state_q <= RUN;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Counters must never wrap; a violation means an upstream protocol error
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(outst_q) + int'(fire) - int'(ic_resp_i) >= 0);
      assert (int'(outst_q) + int'(fire) - int'(ic_resp_i) <= MAX_OUTST);
      if (!flush_q) begin
        assert (int'(used_q) + int'(fire) - int'(iq_deq_cnt_i) - int'(stale_resp) >= 0);
        assert (int'(used_q) + int'(fire) - int'(iq_deq_cnt_i) - int'(stale_resp) <= IQ_DEPTH);
      end
    end
  end

  assign redir_o    = redir_q;
  assign redir_pc_o = redir_pc_q;
  assign flush_o    = flush_q;
  assign epoch_o    = epoch_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, corner sequences, random traffic.
// Reference model tracks in-flight request tags and instQueue occupancy directly.
// Outputs are sampled on the falling edge, stall 1ns after inputs are driven.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               ic_init_done_i;
  logic               wb_redir_i;
  logic [63:0]        wb_redir_pc_i;
  logic               dec_redir_i;
  logic [63:0]        dec_redir_pc_i;
  logic [EPOCH_W-1:0] dec_epoch_i;
  logic               bp_redir_i;
  logic [63:0]        bp_redir_pc_i;
  logic               f0_valid_i;
  logic               ic_ready_i;
  logic               ic_resp_i;
  logic [EPOCH_W-1:0] ic_resp_epoch_i;
  logic [DEQ_CW-1:0]  iq_deq_cnt_i;
  logic               redir_o;
  logic [63:0]        redir_pc_o;
  logic               stall_f0_o;
  logic               flush_o;
  logic [EPOCH_W-1:0] epoch_o;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ic_init_done_i  (ic_init_done_i),
    .wb_redir_i      (wb_redir_i),
    .wb_redir_pc_i   (wb_redir_pc_i),
    .dec_redir_i     (dec_redir_i),
    .dec_redir_pc_i  (dec_redir_pc_i),
    .dec_epoch_i     (dec_epoch_i),
    .bp_redir_i      (bp_redir_i),
    .bp_redir_pc_i   (bp_redir_pc_i),
    .f0_valid_i      (f0_valid_i),
    .ic_ready_i      (ic_ready_i),
    .ic_resp_i       (ic_resp_i),
    .ic_resp_epoch_i (ic_resp_epoch_i),
    .iq_deq_cnt_i    (iq_deq_cnt_i),
    .redir_o         (redir_o),
    .redir_pc_o      (redir_pc_o),
    .stall_f0_o      (stall_f0_o),
    .flush_o         (flush_o),
    .epoch_o         (epoch_o)
  );

  typedef struct {
    logic        wb;
    logic [63:0] wb_pc;
    logic        dec;
    logic [63:0] dec_pc;
    int          dec_ep;
    logic        bp;
    logic [63:0] bp_pc;
    logic        f0v;
    logic        rdy;
    logic        resp;
    int          deq;
  } stim_t;

  typedef struct {
    logic        wb;
    logic        dec;
    logic        dmatch;
    logic        bp;
    logic [63:0] wb_pc;
    logic [63:0] dec_pc;
    logic [63:0] bp_pc;
    logic        exp_redir;
    logic [63:0] exp_pc;
    logic        exp_flush;
    int          ep_inc;
  } vec_t;

  localparam int M_INIT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_REDIR = 2;

  int          n_checks = 0;
  int          n_fails  = 0;
  string       phase    = "reset";

  // Reference model state
  int          m_state;
  logic        m_redir;
  logic [63:0] m_pc;
  logic        m_flush;
  int          m_epoch;
  logic        m_pend;
  logic [63:0] m_pend_pc;
  int          inflight[$];
  int          iq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.wb = 1'b0; s.wb_pc = '0; s.dec = 1'b0; s.dec_pc = '0; s.dec_ep = 0;
    s.bp = 1'b0; s.bp_pc = '0; s.f0v = 1'b0; s.rdy = 1'b1; s.resp = 1'b0; s.deq = 0;
    return s;
  endfunction

  task automatic model_reset();
    m_state = M_INIT; m_redir = 1'b0; m_pc = '0; m_flush = 1'b0; m_epoch = 0;
    m_pend = 1'b0; m_pend_pc = '0; inflight.delete(); iq = 0;
  endtask

  // Reset applied for one edge, outputs checked against reset values
  task automatic do_reset();
    stim_t s;
    s = idle();
    rst = 1'b1; ic_init_done_i = 1'b0;
    wb_redir_i = 1'b0; wb_redir_pc_i = '0; dec_redir_i = 1'b0; dec_redir_pc_i = '0;
    dec_epoch_i = '0; bp_redir_i = 1'b0; bp_redir_pc_i = '0; f0_valid_i = 1'b0;
    ic_ready_i = s.rdy; ic_resp_i = 1'b0; ic_resp_epoch_i = '0; iq_deq_cnt_i = '0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check({phase, ".rst_redir"}, redir_o, 0);
    check({phase, ".rst_pc"}, redir_pc_o, 0);
    check({phase, ".rst_flush"}, flush_o, 0);
    check({phase, ".rst_stall"}, stall_f0_o, 1);
    check({phase, ".rst_epoch"}, epoch_o, 0);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, check stall, advance the model, check registered outputs
  task automatic step(input stim_t s);
    bit exp_stall, fire, resp;
    int tag, win, t;
    resp = s.resp && (inflight.size() > 0);
    tag  = resp ? inflight[0] : 0;
    wb_redir_i = s.wb;   wb_redir_pc_i = s.wb_pc;
    dec_redir_i = s.dec; dec_redir_pc_i = s.dec_pc; dec_epoch_i = EPOCH_W'(s.dec_ep);
    bp_redir_i = s.bp;   bp_redir_pc_i = s.bp_pc;
    f0_valid_i = s.f0v;  ic_ready_i = s.rdy;
    ic_resp_i = resp;    ic_resp_epoch_i = EPOCH_W'(tag);
    iq_deq_cnt_i = DEQ_CW'(s.deq);
    #1;
    exp_stall = (m_state != M_RUN) || (inflight.size() + iq >= IQ_DEPTH) ||
                (inflight.size() >= MAX_OUTST) || !s.rdy;
    check({phase, ".stall"}, stall_f0_o, exp_stall);
    fire = s.f0v && s.rdy && !exp_stall;

    if (m_state == M_INIT) begin
      m_redir = 1'b0;
      m_flush = 1'b0;
      if (s.wb) begin m_pend = 1'b1; m_pend_pc = s.wb_pc; end
      if (ic_init_done_i) begin
        m_state = M_RUN;
        if (m_pend) begin m_redir = 1'b1; m_pc = m_pend_pc; end
        m_pend = 1'b0;
      end
    end else begin
      win = 0;
      if (s.wb) win = 1;
      else if (s.dec && s.dec_ep == m_epoch) win = 2;
      else if (s.bp) win = 3;
      if (resp) begin
        t = inflight.pop_front();
        if (t == m_epoch) iq++;
      end
      if (fire) inflight.push_back(m_epoch);
      iq -= s.deq;
      if (m_flush) iq = 0;
      m_flush = (win == 1);
      m_redir = (win != 0);
      if (win == 1) m_pc = s.wb_pc;
      if (win == 2) m_pc = s.dec_pc;
      if (win == 3) m_pc = s.bp_pc;
      if (win == 1 || win == 2) m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
      m_state = (win != 0) ? M_REDIR : M_RUN;
    end

    @(posedge clk);
    @(negedge clk);
    check({phase, ".redir"}, redir_o, m_redir);
    check({phase, ".flush"}, flush_o, m_flush);
    check({phase, ".epoch"}, epoch_o, m_epoch);
    if (m_redir) check({phase, ".redir_pc"}, redir_pc_o, m_pc);
  endtask

  // Eight fires with each previous request returning, so the pool fills exactly
  task automatic fill8();
    stim_t s;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      s = idle();
      s.f0v = 1'b1;
      s.resp = (inflight.size() > 0);
      step(s);
    end
  endtask

  task automatic drain();
    stim_t s;
    for (int i = 0; i < 2 * IQ_DEPTH; i++) begin
      s = idle();
      s.resp = (inflight.size() > 0);
      s.deq = m_flush ? 0 : ((iq < DEQ_W) ? iq : DEQ_W);
      step(s);
    end
  endtask

  vec_t  vecs[8];
  stim_t s;
  int    exp_ep;
  int    e0;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0100, 64'h200, 64'h300, 1'b1, 64'h8000_0100, 1'b1, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 64'h220, 64'h0, 1'b0, 64'h0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 64'h240, 64'h0, 1'b1, 64'h240, 1'b0, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h260, 64'h300, 1'b1, 64'h300, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 64'h380, 1'b1, 64'h380, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h0, 64'h400, 64'h480, 1'b1, 64'h400, 1'b0, 1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h9000, 64'h0, 64'h0, 1'b1, 64'h9000, 1'b1, 1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 0};

    rst = 1'b1;
    do_reset();

    // Icache not ready for five cycles, then release
    phase = "init_wait";
    for (int i = 0; i < 5; i++) begin
      step(idle());
      check("init_wait.stall_held", stall_f0_o, 1);
    end
    ic_init_done_i = 1'b1;
    step(idle());
    check("init_done.stall_clear", stall_f0_o, 0);

    // Arbitration table, epoch tracked from the table's own increments
    phase = "arb_table";
    exp_ep = 0;
    for (int i = 0; i < 8; i++) begin
      s = idle();
      s.wb = vecs[i].wb;   s.wb_pc = vecs[i].wb_pc;
      s.dec = vecs[i].dec; s.dec_pc = vecs[i].dec_pc;
      s.dec_ep = vecs[i].dmatch ? exp_ep : (exp_ep + 3) % 4;
      s.bp = vecs[i].bp;   s.bp_pc = vecs[i].bp_pc;
      step(s);
      exp_ep = (exp_ep + vecs[i].ep_inc) % 4;
      check("arb_table.vec_redir", redir_o, vecs[i].exp_redir);
      check("arb_table.vec_flush", flush_o, vecs[i].exp_flush);
      check("arb_table.vec_epoch", epoch_o, exp_ep);
      if (vecs[i].exp_redir) check("arb_table.vec_pc", redir_pc_o, vecs[i].exp_pc);
    end

    // Pool fills after eight fires; a pop lifts the stall only on the next cycle
    phase = "iq_full";
    fill8();
    check("iq_full.stall_at_8", stall_f0_o, 1);
    s = idle(); s.f0v = 1'b1; s.resp = 1'b1;
    step(s);
    s = idle(); s.f0v = 1'b1; s.deq = 1;
    step(s);
    check("iq_full.stall_after_deq", stall_f0_o, 0);
    drain();

    // Three in flight, writeback flush, three stale returns release everything
    phase = "stale_flush";
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.f0v = 1'b1;
      step(s);
    end
    s = idle(); s.wb = 1'b1; s.wb_pc = 64'hA000;
    step(s);
    check("stale_flush.flush", flush_o, 1);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.resp = 1'b1;
      step(s);
    end
    check("stale_flush.stall_free", stall_f0_o, 0);
    fill8();
    check("stale_flush.refill_stall", stall_f0_o, 1);
    drain();

    // Four matching decode redirects walk the epoch through its wrap
    phase = "epoch_wrap";
    e0 = m_epoch;
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.dec = 1'b1; s.dec_pc = 64'h1000 + 64'(i * 16); s.dec_ep = m_epoch;
      step(s);
      check("epoch_wrap.epoch", epoch_o, (e0 + i + 1) % 4);
    end
    s = idle(); s.wb = 1'b1; s.wb_pc = 64'hB000;
    step(s);
    check("epoch_wrap.in_redir", redir_o, 1);
    phase = "rst_in_redir";
    do_reset();

    // Writeback seen during init is replayed on the first RUN cycle
    phase = "init_pend";
    s = idle(); s.wb = 1'b1; s.wb_pc = 64'h1234;
    step(s);
    step(idle());
    ic_init_done_i = 1'b1;
    step(idle());
    check("init_pend.redir", redir_o, 1);
    check("init_pend.pc", redir_pc_o, 64'h1234);
    check("init_pend.epoch", epoch_o, 0);
    check("init_pend.flush", flush_o, 0);
    step(idle());

    // Random traffic against the model
    phase = "random";
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.wb = ($urandom_range(0, 24) == 0);
      s.wb_pc = {$urandom, $urandom};
      s.dec = ($urandom_range(0, 9) == 0);
      s.dec_pc = {$urandom, $urandom};
      s.dec_ep = ($urandom_range(0, 1) == 1) ? m_epoch : int'($urandom_range(0, 3));
      s.bp = ($urandom_range(0, 7) == 0);
      s.bp_pc = {$urandom, $urandom};
      s.f0v = ($urandom_range(0, 3) != 0);
      s.rdy = ($urandom_range(0, 4) != 0);
      s.resp = (inflight.size() > 0) && ($urandom_range(0, 2) != 0);
      s.deq = m_flush ? 0 : int'($urandom_range(0, (iq < DEQ_W) ? iq : DEQ_W));
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
